shift_ctrl: RTL and testbench

- Automatic shift controller for the 40-bit-accumulator to 16-bit output stage.
- Watches the same 40-bit unsigned accumulator stream that feeds the output shifter and drives its `shift` select.
- Increases shift immediately when a sample would overflow 16 bits (attack).
- Decreases shift one step per quiet window after a hold period (decay).
- Sits between the DSP accumulator and the output shifter; its `shift` port connects directly to the shifter's `shift` input.

---
 rtl/dsp_pkg.sv | 42 ++++
 rtl/lead_one_40.sv | 27 ++
 rtl/shift_ctrl.sv | 138 +++++++++++++
 tb/tb_shift_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the accumulator-to-output stage.
//   ACC_W / OUT_W   : accumulator width and output sample width
//   MAX_SHIFT_LIMIT : largest shift that is meaningful (ACC_W - OUT_W)
//   sc_state_e      : shift controller state (TRACK / HOLD)
//   need_from_msb() : minimum shift so that the sample fits in OUT_W bits
// -----------------------------------------------------------------------------
package dsp_pkg;

    localparam int ACC_W           = 40;
    localparam int OUT_W           = 16;
    localparam int MAX_SHIFT_LIMIT = 24;

    // msb index spans 0..39, needs 6 bits; a shift need spans 0..24, needs 5.
    localparam int MSB_W  = 6;
    localparam int NEED_W = 5;

    typedef enum logic {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } sc_state_e;

    // need(x) = max(0, msb_index(x) - (OUT_W-1)), clamped to max_shift.
    // A zero sample needs no shift regardless of the encoder's index output.
    function automatic logic [NEED_W-1:0] need_from_msb(
        input logic [MSB_W-1:0]  msb,
        input logic              zero,
        input logic [NEED_W-1:0] max_shift
    );
        logic [MSB_W-1:0] raw;
        raw = '0;
        if (!zero && (msb > MSB_W'(OUT_W - 1))) begin
            raw = msb - MSB_W'(OUT_W - 1);
        end
        if (raw > {1'b0, max_shift}) begin
            raw = {1'b0, max_shift};
        end
        return raw[NEED_W-1:0];
    endfunction

endpackage

// File: rtl/lead_one_40.sv
// -----------------------------------------------------------------------------
// lead_one_40
// Combinational 40-bit priority encoder (leading one detector).
//   x         in  ACC_W  value to encode
//   msb_index out MSB_W  index of the highest set bit (0 when x == 0)
//   zero      out 1      high when x == 0
// -----------------------------------------------------------------------------
module lead_one_40
    import dsp_pkg::*;
(
    input  logic [ACC_W-1:0] x,
    output logic [MSB_W-1:0] msb_index,
    output logic             zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        msb_index = '0;
        zero      = (x == '0);
        for (int i = 0; i < ACC_W; i++) begin
            if (x[i]) begin
                msb_index = MSB_W'(i);
            end
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ctrl
// Automatic shift controller for the 40-bit accumulator -> 16-bit output
// shifter. Raises shift immediately when a sample would overflow (attack) and
// lowers it one step per quiet window once a hold period has expired (decay).
//   ck      in  1        clock, posedge
//   rst     in  1        synchronous reset, active-high
//   en      in  1        sample strobe
//   in      in  ACC_W    unsigned accumulator sample
//   shift   out SHIFT_W  shift select for the output shifter
//   changed out 1        one-cycle pulse when shift takes a new value
//   hold    out 1        high while decay is blocked (state HOLD)
//
// Handshake: en is a pure valid strobe with no ready/back-pressure; every
// posedge with en=1 consumes `in`. Idle cycles (en=0) do not advance windows.
//
// Pipeline: stage 1 registers need(in); stage 2 applies attack/decay one
// posedge later, so shift moves on the second posedge counted from sampling.
// -----------------------------------------------------------------------------
module shift_ctrl
    import dsp_pkg::*;
#(
    parameter int SHIFT_W    = 5,
    parameter int WINDOW     = 256,
    parameter int HOLD_WIN   = 4,
    parameter int INIT_SHIFT = 0,
    parameter int MAX_SHIFT  = 24
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic [ACC_W-1:0]   in,
    output logic [SHIFT_W-1:0] shift,
    output logic               changed,
    output logic               hold
);

    localparam int WIN_CW  = $clog2(WINDOW);
    localparam int HOLD_CW = $clog2(HOLD_WIN + 1);

    // ---------------- stage 1: need(in) ----------------
    logic [MSB_W-1:0]  msb_idx;
    logic              msb_zero;

    logic              v_q,    v_d;
    logic [NEED_W-1:0] need_q, need_d;

    lead_one_40 u_lead (
        .x         (in),
        .msb_index (msb_idx),
        .zero      (msb_zero)
    );

    always_comb begin
        v_d    = en;
        need_d = need_q;
        if (en) begin
            need_d = need_from_msb(msb_idx, msb_zero, NEED_W'(MAX_SHIFT));
        end
    end

    // ---------------- stage 2: attack / decay FSM ----------------
    sc_state_e            state_q,    state_d;
    logic [SHIFT_W-1:0]   shift_q,    shift_d;
    logic                 changed_q,  changed_d;
    logic [WIN_CW-1:0]    win_cnt_q,  win_cnt_d;
    logic [NEED_W-1:0]    peak_q,     peak_d;
    logic [HOLD_CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NEED_W-1:0]    p;

    always_comb begin
        // p is the window peak including the sample being evaluated now.
        p          = (need_q > peak_q) ? need_q : peak_q;

        state_d    = state_q;
        shift_d    = shift_q;
        changed_d  = 1'b0;
        win_cnt_d  = win_cnt_q;
        peak_d     = peak_q;
        hold_cnt_d = hold_cnt_q;

        if (v_q) begin
            if (int'(need_q) > int'(shift_q)) begin
                // Attack outranks a coincident window end: the window restarts
                // and no decay is applied on this sample.
                shift_d    = SHIFT_W'(need_q);
                changed_d  = 1'b1;
                state_d    = HOLD;
                hold_cnt_d = HOLD_CW'(HOLD_WIN);
                win_cnt_d  = '0;
                peak_d     = '0;
            end else if (win_cnt_q == WIN_CW'(WINDOW - 1)) begin
                win_cnt_d = '0;
                peak_d    = '0;
                if (state_q == HOLD) begin
                    hold_cnt_d = hold_cnt_q - HOLD_CW'(1);
                    if (hold_cnt_q == HOLD_CW'(1)) begin
                        state_d = TRACK;
                    end
                end else if (int'(p) < int'(shift_q)) begin
                    // p < shift guarantees shift >= 1, so no underflow.
                    shift_d   = shift_q - SHIFT_W'(1);
                    changed_d = 1'b1;
                end
            end else begin
                win_cnt_d = win_cnt_q + WIN_CW'(1);
                peak_d    = p;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            v_q        <= 1'b0;
            need_q     <= '0;
            state_q    <= TRACK;
            shift_q    <= SHIFT_W'(INIT_SHIFT);
            changed_q  <= 1'b0;
            win_cnt_q  <= '0;
            peak_q     <= '0;
            hold_cnt_q <= '0;
        end else begin
            v_q        <= v_d;
            need_q     <= need_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            changed_q  <= changed_d;
            win_cnt_q  <= win_cnt_d;
            peak_q     <= peak_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign shift   = shift_q;
    assign changed = changed_q;
    assign hold    = (state_q == HOLD);

endmodule

// File: tb/tb_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_ctrl
// Directed bench for shift_ctrl with WINDOW=4, HOLD_WIN=2. A second instance
// with INIT_SHIFT=7 shares the same stimulus and is only checked at reset.
// -----------------------------------------------------------------------------
module tb_shift_ctrl;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [39:0] in = '0;

    logic [4:0]  shift;
    logic        changed;
    logic        hold;
    logic [4:0]  shift7;
    logic        changed7;
    logic        hold7;

    int n_tests = 0;
    int n_fail  = 0;

    shift_ctrl #(.SHIFT_W(5), .WINDOW(4), .HOLD_WIN(2), .INIT_SHIFT(0), .MAX_SHIFT(24)) dut (
        .ck(ck), .rst(rst), .en(en), .in(in),
        .shift(shift), .changed(changed), .hold(hold)
    );

    shift_ctrl #(.SHIFT_W(5), .WINDOW(4), .HOLD_WIN(2), .INIT_SHIFT(7), .MAX_SHIFT(24)) dut7 (
        .ck(ck), .rst(rst), .en(en), .in(in),
        .shift(shift7), .changed(changed7), .hold(hold7)
    );

    // ---------------- clock ----------------
    always #5 ck = ~ck;

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        in  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Back-to-back sample: stage-1 capture on this edge.
    task automatic push(input logic [39:0] v);
        en = 1'b1;
        in = v;
        tick();
        en = 1'b0;
    endtask

    // Isolated sample followed by one idle cycle, so outputs reflect it.
    task automatic sample(input logic [39:0] v);
        push(v);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++; if (shift !== 5'd0)   begin n_fail++; $display("FAIL reset_shift got %0d exp 0", shift); end
        n_tests++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %0b exp 0", changed); end
        n_tests++; if (hold !== 1'b0)    begin n_fail++; $display("FAIL reset_hold got %0b exp 0", hold); end
        n_tests++; if (shift7 !== 5'd7)  begin n_fail++; $display("FAIL reset_init7 got %0d exp 7", shift7); end
        // Small samples never need a shift.
        for (int i = 0; i < 8; i++) begin
            push(40'h00_0000_1234);
            n_tests++;
            if (shift !== 5'd0 || changed !== 1'b0) begin
                n_fail++; $display("FAIL small_in[%0d] shift=%0d changed=%0b exp 0/0", i, shift, changed);
            end
        end
        tick();
        n_tests++; if (shift !== 5'd0 || changed !== 1'b0 || hold !== 1'b0) begin
            n_fail++; $display("FAIL small_in_drain shift=%0d changed=%0b hold=%0b exp 0/0/0", shift, changed, hold);
        end
    endtask

    task automatic test_attack();
        do_reset();
        push(40'h00_0001_0000);
        // One edge after sampling the shift must not have moved yet.
        n_tests++; if (shift !== 5'd0 || changed !== 1'b0) begin
            n_fail++; $display("FAIL attack_latency shift=%0d changed=%0b exp 0/0", shift, changed);
        end
        tick();
        n_tests++; if (shift !== 5'd1 || changed !== 1'b1 || hold !== 1'b1) begin
            n_fail++; $display("FAIL attack_need1 shift=%0d changed=%0b hold=%0b exp 1/1/1", shift, changed, hold);
        end
        tick();
        n_tests++; if (shift !== 5'd1 || changed !== 1'b0) begin
            n_fail++; $display("FAIL attack_pulse_width shift=%0d changed=%0b exp 1/0", shift, changed);
        end
        sample(40'h80_0000_0000);
        n_tests++; if (shift !== 5'd24 || changed !== 1'b1 || hold !== 1'b1) begin
            n_fail++; $display("FAIL attack_max shift=%0d changed=%0b hold=%0b exp 24/1/1", shift, changed, hold);
        end
    endtask

    task automatic test_decay();
        logic [4:0] e_shift;
        logic       e_hold;
        logic       e_chg;
        do_reset();
        sample(40'h00_0004_0000);
        n_tests++; if (shift !== 5'd3 || changed !== 1'b1 || hold !== 1'b1) begin
            n_fail++; $display("FAIL decay_attack shift=%0d changed=%0b hold=%0b exp 3/1/1", shift, changed, hold);
        end
        // Samples 1..7 still in hold; hold ends at 8; decays land on 12,16,20.
        for (int j = 1; j <= 27; j++) begin
            sample(40'h00_0000_00FF);
            e_hold  = (j < 8);
            e_shift = (j < 12) ? 5'd3 : (j < 16) ? 5'd2 : (j < 20) ? 5'd1 : 5'd0;
            e_chg   = (j == 12 || j == 16 || j == 20);
            n_tests++;
            if (shift !== e_shift || hold !== e_hold || changed !== e_chg) begin
                n_fail++;
                $display("FAIL decay[%0d] shift=%0d hold=%0b changed=%0b exp %0d/%0b/%0b",
                         j, shift, hold, changed, e_shift, e_hold, e_chg);
            end
        end
    endtask

    task automatic test_back_to_back_peak();
        do_reset();
        sample(40'h00_0004_0000);
        for (int j = 0; j < 8; j++) sample(40'h0);
        n_tests++; if (shift !== 5'd3 || hold !== 1'b0) begin
            n_fail++; $display("FAIL peak_setup shift=%0d hold=%0b exp 3/0", shift, hold);
        end
        // Four windows, each with one need=3 sample at a different position.
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                push((k == w) ? 40'h00_0004_0000 : 40'h0);
                n_tests++;
                if (shift !== 5'd3 || changed !== 1'b0 || hold !== 1'b0) begin
                    n_fail++;
                    $display("FAIL peak_hold[w%0d k%0d] shift=%0d changed=%0b hold=%0b exp 3/0/0",
                             w, k, shift, changed, hold);
                end
            end
        end
        tick();
        n_tests++; if (shift !== 5'd3 || changed !== 1'b0) begin
            n_fail++; $display("FAIL peak_drain shift=%0d changed=%0b exp 3/0", shift, changed);
        end
        // A window of zeros then decays exactly at its 4th sample.
        for (int j = 0; j < 3; j++) sample(40'h0);
        n_tests++; if (shift !== 5'd3) begin
            n_fail++; $display("FAIL peak_quiet_early shift=%0d exp 3", shift);
        end
        sample(40'h0);
        n_tests++; if (shift !== 5'd2 || changed !== 1'b1) begin
            n_fail++; $display("FAIL peak_quiet_decay shift=%0d changed=%0b exp 2/1", shift, changed);
        end
    endtask

    task automatic test_attack_at_window_end();
        do_reset();
        sample(40'h00_0002_0000);
        for (int j = 0; j < 8; j++) sample(40'h0);
        n_tests++; if (shift !== 5'd2 || hold !== 1'b0) begin
            n_fail++; $display("FAIL wend_setup shift=%0d hold=%0b exp 2/0", shift, hold);
        end
        for (int j = 0; j < 3; j++) sample(40'h0);
        sample(40'h00_0010_0000);
        n_tests++; if (shift !== 5'd5 || changed !== 1'b1 || hold !== 1'b1) begin
            n_fail++; $display("FAIL wend_attack shift=%0d changed=%0b hold=%0b exp 5/1/1", shift, changed, hold);
        end
        // If the window restarted, hold lasts exactly 8 more samples.
        for (int j = 0; j < 7; j++) sample(40'h0);
        n_tests++; if (hold !== 1'b1 || shift !== 5'd5) begin
            n_fail++; $display("FAIL wend_hold7 hold=%0b shift=%0d exp 1/5", hold, shift);
        end
        sample(40'h0);
        n_tests++; if (hold !== 1'b0 || shift !== 5'd5) begin
            n_fail++; $display("FAIL wend_hold8 hold=%0b shift=%0d exp 0/5", hold, shift);
        end
        for (int j = 0; j < 4; j++) sample(40'h0);
        n_tests++; if (shift !== 5'd4 || changed !== 1'b1) begin
            n_fail++; $display("FAIL wend_decay shift=%0d changed=%0b exp 4/1", shift, changed);
        end
    endtask

    task automatic test_reset_drops_inflight();
        do_reset();
        push(40'h00_0020_0000);   // need = 6, captured on edge N
        rst = 1'b1;
        tick();                   // edge N+1
        n_tests++; if (shift !== 5'd0 || changed !== 1'b0 || hold !== 1'b0) begin
            n_fail++; $display("FAIL drop_n1 shift=%0d changed=%0b hold=%0b exp 0/0/0", shift, changed, hold);
        end
        rst = 1'b0;
        tick();                   // edge N+2
        n_tests++; if (shift !== 5'd0 || changed !== 1'b0 || hold !== 1'b0) begin
            n_fail++; $display("FAIL drop_n2 shift=%0d changed=%0b hold=%0b exp 0/0/0", shift, changed, hold);
        end
        n_tests++; if (shift7 !== 5'd7 || changed7 !== 1'b0 || hold7 !== 1'b0) begin
            n_fail++; $display("FAIL drop_init7 shift=%0d changed=%0b hold=%0b exp 7/0/0", shift7, changed7, hold7);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_attack();
        test_decay();
        test_back_to_back_peak();
        test_attack_at_window_end();
        test_reset_drops_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
